// File: rtl/tmds_encoder_3ch.sv
// Three-channel DVI 1.0 TMDS encoder: transition-minimising stage, then a
// DC-balancing stage with per-channel running disparity. Two-cycle latency.
module tmds_encoder_3ch (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       de,
  output logic [9:0] tmds_red,
  output logic [9:0] tmds_green,
  output logic [9:0] tmds_blue
);

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  // Channel index 0 = blue, 1 = green, 2 = red; only blue carries syncs.
  logic [7:0] data_in [3];
  logic [1:0] ctrl_in [3];
  logic [9:0] sym_out [3];

  assign data_in[0] = blue;
  assign data_in[1] = green;
  assign data_in[2] = red;
  assign ctrl_in[0] = {vsync, hsync};
  assign ctrl_in[1] = 2'b00;
  assign ctrl_in[2] = 2'b00;

  assign tmds_blue  = sym_out[0];
  assign tmds_green = sym_out[1];
  assign tmds_red   = sym_out[2];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [3:0]        n1;
      logic              use_xnor;
      logic [8:0]        q_m_d, q_m_q;
      logic              de_q;
      logic [1:0]        ctrl_q;
      logic [3:0]        n1q;
      logic signed [4:0] diff;
      logic signed [4:0] cnt_d, cnt_q;
      logic [9:0]        sym_d, sym_q;

      always_comb begin
        n1 = 4'd0;
        for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, data_in[gi][i]};
        use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !data_in[gi][0]);
        q_m_d    = '0;
        q_m_d[0] = data_in[gi][0];
        for (int i = 1; i < 8; i++)
          q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ data_in[gi][i]) : (q_m_d[i-1] ^ data_in[gi][i]);
        q_m_d[8] = ~use_xnor;
      end

      always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
          q_m_q  <= '0;
          de_q   <= 1'b0;
          ctrl_q <= 2'b00;
        end else begin
          q_m_q  <= q_m_d;
          de_q   <= de;
          ctrl_q <= ctrl_in[gi];
        end
      end

      // diff = N1q - N0q = 2*N1q - 8; fits the 5-bit signed range exactly.
      always_comb begin
        n1q = 4'd0;
        for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, q_m_q[i]};
        diff  = $signed({n1q, 1'b0} - 5'd8);
        sym_d = TOKEN_00;
        cnt_d = cnt_q;
        if (!de_q) begin
          cnt_d = 5'sd0;
          case (ctrl_q)
            2'b00:   sym_d = TOKEN_00;
            2'b01:   sym_d = TOKEN_01;
            2'b10:   sym_d = TOKEN_10;
            default: sym_d = TOKEN_11;
          endcase
        end else if (cnt_q == 5'sd0 || diff == 5'sd0) begin
          sym_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
          cnt_d = q_m_q[8] ? cnt_q + diff : cnt_q - diff;
        end else if ((cnt_q > 5'sd0 && diff > 5'sd0) || (cnt_q < 5'sd0 && diff < 5'sd0)) begin
          sym_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
          cnt_d = cnt_q - diff + (q_m_q[8] ? 5'sd2 : 5'sd0);
        end else begin
          sym_d = {1'b0, q_m_q[8], q_m_q[7:0]};
          cnt_d = cnt_q + diff - (q_m_q[8] ? 5'sd0 : 5'sd2);
        end
      end

      always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
          sym_q <= TOKEN_00;
          cnt_q <= 5'sd0;
        end else begin
          sym_q <= sym_d;
          cnt_q <= cnt_d;
        end
      end

      assign sym_out[gi] = sym_q;
    end
  endgenerate

endmodule

// File: doc/tmds_encoder_3ch.md
# tmds_encoder_3ch

DVI/HDMI TMDS encoder for the three data channels of the Tang Nano 9K HDMI path. It sits between the VGA pixel source (colour, hsync, vsync, de) and the 10:1 serialisers inside the HDMI output stage. Every pixel clock it produces one 10-bit symbol per channel: DVI 1.0 8b/10b video coding with per-channel running disparity during active video, and control tokens during blanking.

## Interface
Parameters:
- none (DVI 1.0 coding is fixed)

Ports:
- clk_pixel  input  1  pixel clock (25 MHz); all registers on its rising edge
- reset  input  1  asynchronous, active-high; forces all state to reset values immediately
- red  input  8  red pixel value, sampled when de=1
- green  input  8  green pixel value, sampled when de=1
- blue  input  8  blue pixel value, sampled when de=1
- hsync  input  1  horizontal sync, carried as C0 on the blue channel
- vsync  input  1  vertical sync, carried as C1 on the blue channel
- de  input  1  display enable; 1 = video period, 0 = control period
- tmds_red  output  10  channel 2 symbol, LSB transmitted first
- tmds_green  output  10  channel 1 symbol
- tmds_blue  output  10  channel 0 symbol

## Operation
- Three identical channel encoders. Control inputs per channel: blue {C1,C0}={vsync,hsync}; green and red {C1,C0}=2'b00.
- Stage 1 (transition minimisation), registered:
  - N1 = popcount(D[7:0]).
  - If N1>4, or N1==4 with D[0]==0: XNOR mode. q_m[0]=D[0], q_m[i]=~(q_m[i-1]^D[i]), q_m[8]=0.
  - Otherwise: XOR mode. q_m[i]=q_m[i-1]^D[i], q_m[8]=1.
  - de and {C1,C0} are registered alongside q_m so that the stage-2 inputs stay aligned.
- Stage 2 (DC balance), registered. N1q=popcount(q_m[7:0]), N0q=8-N1q. cnt is a per-channel signed 5-bit running disparity.
  - de_d=0: output the control token. {C1,C0}=00 gives 10'b1101010100, 01 gives 10'b0010101011, 10 gives 10'b0101010100, 11 gives 10'b1010101011. Set cnt=0.
  - de_d=1, cnt==0 or N1q==N0q:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1q-N0q) : (N0q-N1q).
  - de_d=1, (cnt>0 and N1q>N0q) or (cnt<0 and N0q>N1q):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (N0q-N1q).
  - de_d=1, otherwise:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += (N1q-N0q) - 2*(~q_m[8]).
- Arithmetic is signed, sized so that cnt stays in −16..+15 without wrap. With legal coding, |cnt| never exceeds 10; a bench assertion checks this.
- No handshake. Input is accepted every cycle, and output is valid every cycle after reset release.

## Timing
- Latency is exactly 2 clk_pixel cycles from inputs to the tmds_* outputs for data, de and sync alike. There is no skew between channels.
- Reset (async assert):
  - all tmds_* = 10'b1101010100 (0x354) immediately;
  - cnt=0;
  - stage-1 de=0, controls=00.
  - Reset is released synchronously to clk_pixel by the upstream reset synchroniser.
- First clock edge after reset deassertion: outputs reflect stage-1 contents, i.e. still 0x354. Input-driven output appears on the second edge.
- de falling edge: the first blanking symbol appears 2 cycles later, and cnt is zero from that cycle onward.
- de rising edge: the first video symbol is encoded with cnt=0.
- hsync/vsync toggling while de=1: no effect on video symbols.
- Reset asserted mid-line: outputs go to 0x354 within the same cycle, and pipeline contents are discarded.

## Test plan
- Reset: assert reset with arbitrary inputs → all three outputs = 0x354 asynchronously, and they stay 0x354 for 2 edges after release with de=0, sync=0.
- Control tokens:
  - de=0, {vsync,hsync}=01 → tmds_blue=0x0AB after 2 cycles, red/green=0x354.
  - Then 10 → blue=0x154.
  - Then 11 → blue=0x2AB.
- Disparity sequence: de=1, blue=0x00 for 3 cycles from a blanking start → tmds_blue = 0x100, 0x3FF, 0x100. Internal cnt after each symbol = −8, +2, −6.
- XNOR path: de=1, green=0xFF from cnt=0 → tmds_green=0x200, cnt=−8.
- Blanking resets disparity: after the 3-pixel 0x00 run, de=0 for 1 cycle, then blue=0x00 → 0x100 again (not 0x3FF).
- Random soak: 10k random pixels with periodic blanking, compared against a reference model. Also checked: every symbol decodes back to its input, |cnt|≤10, and the 2-cycle alignment of de and sync is exact across all channels.
